// File: rtl/pe_sum_drain.sv
// Output drain for the systolic PE array: realigns skewed column sums into
// whole rows, buffers them in a row FIFO and streams them one word at a time.
module pe_sum_drain #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned SUM_W = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  row_valid,
    input  logic [COLS*SUM_W-1:0] sum_in,
    input  logic                  clear,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SUM_W-1:0]      m_data,
    output logic                  m_last,
    output logic                  overflow,
    output logic [15:0]           rows_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef logic [COLS-1:0][SUM_W-1:0] row_t;

    logic [COLS-2:0]  r_tag;
    row_t             w_sum;
    row_t             w_row;
    row_t             r_mem [DEPTH];
    row_t             w_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [COL_W-1:0] r_col_idx;
    logic             r_overflow;
    logic [15:0]      r_rows_out;

    logic w_full;
    logic w_xfer;
    logic w_col_last;
    logic w_pop;
    logic w_wr_tag;
    logic w_push;
    logic w_drop;

    assign w_sum = sum_in;

    // r_tag[k] is row_valid delayed k+1 cycles; the top tag marks an aligned row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else begin
            r_tag <= (COLS-1)'({r_tag, row_valid});
        end
    end

    assign w_wr_tag = r_tag[COLS-2];

    // Column c sits in a COLS-1-c stage line; a free-running shift lands the
    // value sampled under its tag exactly when the row tag reaches the top.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_dly
        localparam int N = COLS - 1 - c;
        logic [SUM_W-1:0] r_dly [N];

        always_ff @(posedge clk) begin
            r_dly[0] <= w_sum[c];
            for (int k = 1; k < N; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end

        assign w_row[c] = r_dly[N-1];
    end
    assign w_row[COLS-1] = w_sum[COLS-1];

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_xfer     = m_valid && m_ready;
    assign w_col_last = (r_col_idx == COL_W'(COLS - 1));
    assign w_pop      = w_xfer && w_col_last;
    // A pop in the same cycle frees the slot the incoming row needs
    assign w_push     = w_wr_tag && (!w_full || w_pop);
    assign w_drop     = w_wr_tag && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_col_idx  <= '0;
            r_overflow <= 1'b0;
            r_rows_out <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_xfer) begin
                r_col_idx <= w_col_last ? '0 : r_col_idx + COL_W'(1);
            end
            // A drop coinciding with clear still leaves the sticky flag set
            if (clear) begin
                r_overflow <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (clear) begin
                r_rows_out <= '0;
            end else if (w_pop) begin
                r_rows_out <= r_rows_out + 16'd1;
            end
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign m_valid  = (r_count != '0);
    assign m_data   = m_valid ? w_head[r_col_idx] : '0;
    assign m_last   = m_valid && w_col_last;
    assign overflow = r_overflow;
    assign rows_out = r_rows_out;

endmodule

// File: tb/tb_pe_sum_drain.sv
// Randomized bench for pe_sum_drain against a row-queue reference model,
// with directed scenarios pinned by hand-computed expectations.
module tb_pe_sum_drain;

    localparam int COLS  = 4;
    localparam int SUM_W = 32;
    localparam int DEPTH = 8;
    localparam int MAXC  = 8192;

    typedef logic [COLS-1:0][SUM_W-1:0] mrow_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  row_valid = 1'b0;
    logic [COLS*SUM_W-1:0] sum_in = '0;
    logic                  clear = 1'b0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [SUM_W-1:0]      m_data;
    logic                  m_last;
    logic                  overflow;
    logic [15:0]           rows_out;

    pe_sum_drain #(.COLS(COLS), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .row_valid(row_valid), .sum_in(sum_in),
        .clear(clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .overflow(overflow), .rows_out(rows_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: input history plus a queue of whole rows
    bit                    hist_v [MAXC];
    logic [COLS*SUM_W-1:0] hist_d [MAXC];
    mrow_t                 mq [$];
    int                    mcol  = 0;
    bit                    movf  = 1'b0;
    logic [15:0]           mrows = '0;
    bit                    armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        bit ev;
        if (!armed) return;
        ev = (mq.size() > 0);
        check("m_valid", 32'(m_valid), 32'(ev));
        if (ev) begin
            check("m_data", m_data, mq[0][mcol]);
            check("m_last", 32'(m_last), 32'(mcol == COLS - 1));
        end else begin
            check("m_data_idle", m_data, 32'h0);
            check("m_last_idle", 32'(m_last), 32'h0);
        end
        check("overflow", 32'(overflow), 32'(movf));
        check("rows_out", 32'(rows_out), 32'(mrows));
    endtask

    task automatic model_step(input logic rv, input logic [COLS*SUM_W-1:0] s,
                              input logic rdy, input logic clr, input logic rs);
        int    t;
        bit    xfer, pop, wr, drop;
        mrow_t row;
        hist_v[cyc % MAXC] = rv;
        hist_d[cyc % MAXC] = s;
        if (rs) begin
            mq.delete();
            mcol  = 0;
            movf  = 1'b0;
            mrows = '0;
            // Any row whose alignment completes at or after reset is lost
            for (int j = 0; j < COLS; j++)
                if (cyc - j >= 0) hist_v[(cyc - j) % MAXC] = 1'b0;
            armed = 1'b1;
            return;
        end
        xfer = (mq.size() > 0) && rdy;
        pop  = xfer && (mcol == COLS - 1);
        t    = cyc - (COLS - 1);
        wr   = (t >= 0) && hist_v[t % MAXC];
        row  = '0;
        if (wr)
            for (int c = 0; c < COLS; c++)
                row[c] = hist_d[(t + c) % MAXC][c*SUM_W +: SUM_W];
        if (pop) begin
            void'(mq.pop_front());
            mrows = mrows + 16'd1;
            mcol  = 0;
        end else if (xfer) begin
            mcol++;
        end
        drop = 1'b0;
        if (wr) begin
            if (mq.size() < DEPTH) mq.push_back(row);
            else drop = 1'b1;
        end
        if (clr) begin
            movf  = 1'b0;
            mrows = '0;
        end
        if (drop) movf = 1'b1;
    endtask

    task automatic cycle(input logic rv, input logic [COLS*SUM_W-1:0] s,
                         input logic rdy, input logic clr, input logic rs);
        @(negedge clk);
        compare_outputs();
        row_valid = rv;
        sum_in    = s;
        m_ready   = rdy;
        clear     = clr;
        rst       = rs;
        model_step(rv, s, rdy, clr, rs);
        cyc++;
    endtask

    function automatic logic [COLS*SUM_W-1:0] rand_sum();
        logic [COLS*SUM_W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*SUM_W +: SUM_W] = $urandom;
        return v;
    endfunction

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rand_sum(), rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [COLS*SUM_W-1:0] s;
        int cnt;

        // Reset values
        repeat (3) cycle(1'b0, rand_sum(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_data", m_data, 32'h0);
        check("rst_last", 32'(m_last), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_rows", 32'(rows_out), 32'h0);

        // Single row, column c at relative cycle c
        for (int k = 0; k < 10; k++) begin
            s = rand_sum();
            for (int c = 0; c < COLS; c++)
                if (k == c) s[c*SUM_W +: SUM_W] = 32'h100 + 32'(c);
            cycle(k == 0, s, 1'b1, 1'b0, 1'b0);
            if (k < 4) begin
                check("single_pre", 32'(m_valid), 32'h0);
            end else if (k < 8) begin
                check("single_valid", 32'(m_valid), 32'h1);
                check("single_data", m_data, 32'h100 + 32'(k - 4));
                check("single_last", 32'(m_last), 32'(k == 7));
            end else begin
                check("single_done", 32'(m_valid), 32'h0);
                check("single_rows", 32'(rows_out), 32'h1);
            end
        end

        // Back-to-back rows
        cycle(1'b0, rand_sum(), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, rand_sum(), 1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);
            if (k < 16) check("b2b_nogap", 32'(m_valid), 32'h1);
            if (m_valid) cnt++;
        end
        check("b2b_words", 32'(cnt), 32'd16);
        check("b2b_rows", 32'(rows_out), 32'd4);

        // Backpressure at column 2
        for (int k = 0; k < 14; k++) begin
            s = rand_sum();
            for (int c = 0; c < COLS; c++)
                if (k == c) s[c*SUM_W +: SUM_W] = 32'h200 + 32'(c);
            cycle(k == 0, s, !(k >= 6 && k <= 10), 1'b0, 1'b0);
            if (k >= 6 && k <= 11) begin
                check("bp_valid", 32'(m_valid), 32'h1);
                check("bp_hold", m_data, 32'h202);
                check("bp_last", 32'(m_last), 32'h0);
            end
            if (k == 12) begin
                check("bp_resume", m_data, 32'h203);
                check("bp_resume_last", 32'(m_last), 32'h1);
            end
        end

        // Overflow: DEPTH+1 rows with no drain
        cycle(1'b0, rand_sum(), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cycle(k <= DEPTH, rand_sum(), 1'b0, 1'b0, 1'b0);
            if (k == 11) check("ovf_before", 32'(overflow), 32'h0);
            if (k == 12) check("ovf_set", 32'(overflow), 32'h1);
        end
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);
            if (m_last) cnt++;
        end
        check("ovf_drained_rows", 32'(cnt), 32'(DEPTH));
        check("ovf_rows_out", 32'(rows_out), 32'(DEPTH));
        check("ovf_sticky", 32'(overflow), 32'h1);
        cycle(1'b0, rand_sum(), 1'b1, 1'b1, 1'b0);
        cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);
        check("clr_ovf", 32'(overflow), 32'h0);
        check("clr_rows", 32'(rows_out), 32'h0);

        // Full FIFO: final-word pop coincides with aligned write
        for (int k = 0; k < 12; k++) cycle(k < DEPTH, rand_sum(), 1'b0, 1'b0, 1'b0);
        for (int k = 12; k < 16; k++) cycle(k == 12, rand_sum(), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, rand_sum(), 1'b0, 1'b0, 1'b0);
        check("fullpop_ovf", 32'(overflow), 32'h0);
        check("fullpop_rows", 32'(rows_out), 32'h1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);
            if (m_last) cnt++;
        end
        check("fullpop_drained", 32'(cnt), 32'(DEPTH));
        check("fullpop_total", 32'(rows_out), 32'(DEPTH + 1));

        // Reset with 3 rows buffered and 1 in deskew
        for (int k = 0; k < 10; k++) begin
            cycle(k <= 2 || k == 4, rand_sum(), k > 6, 1'b0, k == 6);
            if (k == 5) check("rstmid_buffered", 32'(m_valid), 32'h1);
            if (k == 7) begin
                check("rstmid_valid", 32'(m_valid), 32'h0);
                check("rstmid_rows", 32'(rows_out), 32'h0);
            end
            if (k == 9) check("rstmid_no_stale", 32'(m_valid), 32'h0);
        end
        idle(10, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(99) < 40, rand_sum(), $urandom_range(99) < 70,
                  $urandom_range(199) == 0, $urandom_range(499) == 0);
        end
        idle(50, 1'b1);
        cycle(1'b0, rand_sum(), 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
